free_list: RTL and testbench

Circular FIFO of free physical register indices for the R10K-style rename path. Sits directly downstream of the retire stage: it absorbs up to `N` freed physical registers per cycle (`phys_regs_retiring`, count `num_retiring`) and supplies up to `N` free registers per cycle to dispatch/rename. It also supports single-cycle head-pointer restore on branch mispredict, using a head snapshot taken at dispatch.

---
 rtl/free_list.sv | 162 ++++++++++++++++
 tb/tb_free_list.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list
//   Circular FIFO of free physical register indices for an R10K-style rename
//   path. Retire pushes up to N freed registers per cycle at the tail. Dispatch
//   pops up to N per cycle from the head. A branch mispredict restores the head
//   pointer in a single cycle from a checkpointed copy.
//
// Ports
//   clock              : single clock, all state updates on posedge
//   reset              : asynchronous, active-low
//   num_retiring       : number of valid slots in phys_regs_retiring (0..N)
//   phys_regs_retiring : freed registers, slot i at [i*IDX_W +: IDX_W]
//   num_allocating     : registers consumed by dispatch this cycle (0..N)
//   alloc_regs         : next N free registers, head first, slot 0 in low bits
//   num_alloc_avail    : min(N, free_count)
//   free_count         : occupied entries (tail - head)
//   head_ptr           : head pointer including wrap bit, for checkpoints
//   restore_valid      : mispredict recovery strobe
//   restore_head       : checkpointed head pointer to reinstate
//
// Optional build macro FREE_LIST_CHECK_EN adds:
//   free_bitmap        : one bit per physical register, set while it is in the list
//   free_list_error    : sticky misuse flag, cleared only by reset
module free_list #(
    parameter int N           = 3,
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    parameter int PTR_W       = $clog2(PHYS_REG_SZ) + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [$clog2(N+1)-1:0]               num_retiring,
    input  logic [N*$clog2(PHYS_REG_SZ)-1:0]     phys_regs_retiring,
    input  logic [$clog2(N+1)-1:0]               num_allocating,
    output logic [N*$clog2(PHYS_REG_SZ)-1:0]     alloc_regs,
    output logic [$clog2(N+1)-1:0]               num_alloc_avail,
    output logic [$clog2(PHYS_REG_SZ):0]         free_count,
    output logic [PTR_W-1:0]                     head_ptr,
    input  logic                                 restore_valid,
    input  logic [PTR_W-1:0]                     restore_head
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic [PHYS_REG_SZ-1:0]               free_bitmap,
    output logic                                 free_list_error
`endif
);

    localparam int IDX_W = $clog2(PHYS_REG_SZ);
    localparam int CNT_W = $clog2(N+1);

    logic [IDX_W-1:0] entry [PHYS_REG_SZ];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] space;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] alloc_eff;
    logic [CNT_W-1:0] ret_eff;

    // Pointers carry a wrap bit, so tail - head in PTR_W bits distinguishes
    // empty (0) from full (PHYS_REG_SZ).
    assign count           = tail - head;
    assign space           = PTR_W'(PHYS_REG_SZ) - count;
    assign free_count      = count;
    assign head_ptr        = head;
    assign num_alloc_avail = (count >= PTR_W'(N)) ? CNT_W'(N) : count[CNT_W-1:0];

    // Over-requests are clamped rather than rejected: dispatch can never take
    // more than is visible, and retires beyond the remaining space are dropped.
    assign alloc_eff = (num_allocating > num_alloc_avail) ? num_alloc_avail : num_allocating;
    assign ret_eff   = (PTR_W'(num_retiring) > space) ? space[CNT_W-1:0] : num_retiring;

    // Restore overrides any allocation in the same cycle; retires still land.
    assign head_next = restore_valid ? restore_head : head + PTR_W'(alloc_eff);
    assign tail_next = tail + PTR_W'(ret_eff);

    always_comb begin
        alloc_regs = '0;
        for (int i = 0; i < N; i++) begin
            alloc_regs[i*IDX_W +: IDX_W] = entry[head[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= PTR_W'(PHYS_REG_SZ - ARCH_REG_SZ);
            for (int i = 0; i < PHYS_REG_SZ; i++) begin
                entry[i] <= (i < PHYS_REG_SZ - ARCH_REG_SZ) ? IDX_W'(ARCH_REG_SZ + i) : '0;
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int i = 0; i < N; i++) begin
                if (i < int'(ret_eff)) begin
                    entry[tail[IDX_W-1:0] + IDX_W'(i)] <= phys_regs_retiring[i*IDX_W +: IDX_W];
                end
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic [PHYS_REG_SZ-1:0] bitmap_next;
    logic                   err_next;
    logic [IDX_W-1:0]       off;
    logic [IDX_W-1:0]       ret_reg;

    always_comb begin
        bitmap_next = free_bitmap;
        err_next    = 1'b0;
        off         = '0;
        ret_reg     = '0;
        if (restore_valid) begin
            // Rebuild from the surviving window restore_head..tail; this
            // cycle's retires are merged in below.
            bitmap_next = '0;
            for (int p = 0; p < PHYS_REG_SZ; p++) begin
                off = IDX_W'(p) - restore_head[IDX_W-1:0];
                if ({1'b0, off} < tail - restore_head) begin
                    bitmap_next[entry[p]] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(alloc_eff)) begin
                    bitmap_next[alloc_regs[i*IDX_W +: IDX_W]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            ret_reg = phys_regs_retiring[i*IDX_W +: IDX_W];
            if (i < int'(ret_eff)) begin
                bitmap_next[ret_reg] = 1'b1;
            end
            if (i < int'(num_retiring)) begin
                if (free_bitmap[ret_reg] || (ret_reg == '0)) begin
                    err_next = 1'b1;
                end
            end
        end
        if (!restore_valid && (num_allocating > num_alloc_avail)) begin
            err_next = 1'b1;
        end
        if ((num_retiring != '0) && (count == PTR_W'(PHYS_REG_SZ))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHYS_REG_SZ; i++) begin
                free_bitmap[i] <= (i >= ARCH_REG_SZ);
            end
            free_list_error <= 1'b0;
        end else begin
            free_bitmap     <= bitmap_next;
            free_list_error <= free_list_error | err_next;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, drain to empty, retire into empty,
// wrap-around, restore with concurrent retire, fill to full and mid-run reset.
module tb_free_list;
    localparam int N     = 3;
    localparam int PHYS  = 64;
    localparam int ARCH  = 32;
    localparam int PTR_W = 7;
    localparam int IDX_W = 6;
    localparam int CNT_W = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [CNT_W-1:0]     num_retiring;
    logic [N*IDX_W-1:0]   phys_regs_retiring;
    logic [CNT_W-1:0]     num_allocating;
    logic [N*IDX_W-1:0]   alloc_regs;
    logic [CNT_W-1:0]     num_alloc_avail;
    logic [IDX_W:0]       free_count;
    logic [PTR_W-1:0]     head_ptr;
    logic                 restore_valid;
    logic [PTR_W-1:0]     restore_head;
`ifdef FREE_LIST_CHECK_EN
    logic [PHYS-1:0]      free_bitmap;
    logic                 free_list_error;
`endif

    free_list #(.N(N), .PHYS_REG_SZ(PHYS), .ARCH_REG_SZ(ARCH), .PTR_W(PTR_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .num_retiring       (num_retiring),
        .phys_regs_retiring (phys_regs_retiring),
        .num_allocating     (num_allocating),
        .alloc_regs         (alloc_regs),
        .num_alloc_avail    (num_alloc_avail),
        .free_count         (free_count),
        .head_ptr           (head_ptr),
        .restore_valid      (restore_valid),
        .restore_head       (restore_head)
`ifdef FREE_LIST_CHECK_EN
        ,
        .free_bitmap        (free_bitmap),
        .free_list_error    (free_list_error)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string tag;
        int    fc;
        int    avail;
        int    a0;
        int    a1;
        int    a2;
        int    hp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input int fc, input int avail,
                            input int a0, input int a1, input int a2, input int hp);
        exp_t e;
        e.tag = tag; e.fc = fc; e.avail = avail;
        e.a0 = a0; e.a1 = a1; e.a2 = a2; e.hp = hp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".free_count"}, 64'(free_count), 64'(e.fc));
            chk({e.tag, ".avail"},      64'(num_alloc_avail), 64'(e.avail));
            chk({e.tag, ".alloc0"},     64'(alloc_regs[0 +: IDX_W]), 64'(e.a0));
            chk({e.tag, ".alloc1"},     64'(alloc_regs[IDX_W +: IDX_W]), 64'(e.a1));
            chk({e.tag, ".alloc2"},     64'(alloc_regs[2*IDX_W +: IDX_W]), 64'(e.a2));
            chk({e.tag, ".head_ptr"},   64'(head_ptr), 64'(e.hp));
        end
    endtask

    task automatic set_in(input int na, input int nr, input int r0, input int r1,
                          input int r2, input int rv, input int rh);
        num_allocating     = CNT_W'(na);
        num_retiring       = CNT_W'(nr);
        phys_regs_retiring = {IDX_W'(r2), IDX_W'(r1), IDX_W'(r0)};
        restore_valid      = rv[0];
        restore_head       = PTR_W'(rh);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset-time list contents: entry j holds ARCH+j for the free half, else 0.
    function automatic int init_e(input int j);
        return (j < PHYS - ARCH) ? ARCH + j : 0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int fc;
        int snap;
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        push_exp("reset_async", 32, 3, 32, 33, 34, 0);
        check_out();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        push_exp("idle", 32, 3, 32, 33, 34, 0);
        tick(); check_out();

        // Drain: 3 per cycle, last cycle clamped to 2.
        for (int k = 1; k <= 11; k++) begin
            set_in(3, 0, 0, 0, 0, 0, 0);
            h  = (k <= 10) ? 3 * k : 32;
            fc = 32 - h;
            push_exp($sformatf("drain%0d", k), fc, (fc < 3) ? fc : 3,
                     init_e(h), init_e(h + 1), init_e(h + 2), h);
            tick(); check_out();
        end
        set_in(3, 0, 0, 0, 0, 0, 0);
        push_exp("empty_alloc", 0, 0, 0, 0, 0, 32);
        tick(); check_out();

        // Retire into empty list while dispatch asks for 3.
        set_in(3, 3, 5, 6, 7, 0, 0);
        push_exp("retire_empty", 3, 3, 5, 6, 7, 32);
        tick(); check_out();

        // Walk head to index 62 with balanced allocate/retire.
        for (int k = 0; k < 10; k++) begin
            set_in(3, 3, 8 + 3 * k, 9 + 3 * k, 10 + 3 * k, 0, 0);
            push_exp($sformatf("walk%0d", k), 3, 3, 8 + 3 * k, 9 + 3 * k, 10 + 3 * k, 35 + 3 * k);
            tick(); check_out();
        end

        // Wrap: head 62 -> 64 (index 0, wrap bit set).
        set_in(2, 2, 50, 51, 0, 0, 0);
        push_exp("wrap", 3, 3, 37, 50, 51, 64);
        tick(); check_out();

        // Grow list, snapshot head, allocate 6, restore with one retire.
        set_in(0, 3, 52, 53, 54, 0, 0);
        push_exp("grow", 6, 3, 37, 50, 51, 64);
        tick(); check_out();
        snap = int'(head_ptr);
        set_in(3, 0, 0, 0, 0, 0, 0);
        push_exp("alloc_a", 3, 3, 52, 53, 54, 67);
        tick(); check_out();
        set_in(3, 0, 0, 0, 0, 0, 0);
        push_exp("alloc_b", 0, 0, 38, 39, 40, 70);
        tick(); check_out();
        set_in(3, 1, 55, 0, 0, 1, snap);
        push_exp("restore", 7, 3, 37, 50, 51, 64);
        tick(); check_out();
        set_in(0, 0, 0, 0, 0, 0, 0);
        push_exp("restore_hold", 7, 3, 37, 50, 51, 64);
        tick(); check_out();

        // Fill toward full; final retires are partially then fully dropped.
        for (int k = 0; k < 18; k++) begin
            set_in(0, 3, 1 + (3 * k) % 30, 1 + (3 * k + 1) % 30, 1 + (3 * k + 2) % 30, 0, 0);
            push_exp($sformatf("fill%0d", k), 10 + 3 * k, 3, 37, 50, 51, 64);
            tick(); check_out();
        end
        set_in(0, 2, 41, 42, 0, 0, 0);
        push_exp("fill_63", 63, 3, 37, 50, 51, 64);
        tick(); check_out();
        set_in(0, 3, 43, 44, 45, 0, 0);
        push_exp("fill_clamp", 64, 3, 37, 50, 51, 64);
        tick(); check_out();
        set_in(0, 3, 46, 47, 48, 0, 0);
        push_exp("full_drop", 64, 3, 37, 50, 51, 64);
        tick(); check_out();
        set_in(3, 0, 0, 0, 0, 0, 0);
        push_exp("alloc_from_full", 61, 3, 52, 53, 54, 67);
        tick(); check_out();

        // Mid-run asynchronous reset with activity on the inputs.
        set_in(3, 3, 9, 10, 11, 0, 0);
        #2 reset = 1'b0;
        #1;
        push_exp("midreset_async", 32, 3, 32, 33, 34, 0);
        check_out();
        tick();
        push_exp("midreset_held", 32, 3, 32, 33, 34, 0);
        check_out();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        push_exp("after_reset", 32, 3, 32, 33, 34, 0);
        tick(); check_out();

`ifdef FREE_LIST_CHECK_EN
        chk("err_after_reset", 64'(free_list_error), 64'd0);
        chk("bitmap_reset", 64'(free_bitmap), 64'hFFFF_FFFF_0000_0000);
        set_in(0, 1, 40, 0, 0, 0, 0);
        push_exp("dup_retire", 33, 3, 32, 33, 34, 0);
        tick(); check_out();
        chk("err_dup_retire", 64'(free_list_error), 64'd1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("err_sticky", 64'(free_list_error), 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule
